ps_bigreg_assembler: RTL and testbench
======================================

// Module: ps_bigreg_assembler
// PURPOSE
//  Sits directly downstream of the AXI mem-map write path. Collects SAMPLES consecutive 16-bit
//  mem-map entries (a PS_BIGREG: seeds, channel mux, sample-discriminator config) into one wide
//  register. Commits that register to the consuming RTL on a write to the matching VALID id.
//  Then sweeps the RPOLL fresh bits of BASE..BASE+SAMPLES clear. One instance per PS_BIGREG.
// PARAMETERS
//  BASE_ID   `PS_SEED_BASE_ID  first mem-map index of the big register
//  SAMPLES   `BATCH_SAMPLES    number of entries; VALID id = BASE_ID+SAMPLES (16 seed, 2 chmux, 16 sdc)
//  ID_W      $clog2(`MEM_SIZE) mem-map index width (8)
//  WORD_W    `WD_DATA_WIDTH    bits taken per entry (16)
// PORTS
//  clk        in   1               system clock, single clock domain
//  rst        in   1               asynchronous, active-high reset
//  wr_en      in   1               mem-map write strobe, one entry per cycle
//  wr_id      in   ID_W            mem-map index being written
//  wr_data    in   `WD_BUS_WIDTH   write data; only [WORD_W-1:0] used, upper bits ignored
//  out_data   out  SAMPLES*WORD_W  committed register; entry k at [k*WORD_W +: WORD_W]
//  out_valid  out  1               committed value available
//  out_ready  in   1               consumer accepts out_data
//  out_partial out 1               committed value had entries not written since last commit
//  clr_en     out  1               fresh-bit clear strobe to mem-map
//  clr_id     out  ID_W            index whose fresh bit is cleared
//  busy       out  1               state != IDLE
// BEHAVIOUR
//  Reset: staging, out_data, word_mask, pending = 0; out_valid, out_partial, clr_en, busy = 0;
//   clr_id = BASE_ID; state IDLE. Reset mid-operation aborts the sweep; fresh bits are not cleared.
//  Staging: in every state, wr_en && BASE_ID <= wr_id < BASE_ID+SAMPLES writes
//   staging[wr_id-BASE_ID] and sets word_mask[wr_id-BASE_ID] on the next edge.
//   Index subtraction is ID_W wide; ids outside the range are ignored.
//  Commit request: wr_en && wr_id == BASE_ID+SAMPLES; wr_data value is ignored.
//   A commit in the same cycle as a staging write captures the staging contents from before that write.
//  FSM states:
//   IDLE  - on a commit request: out_data <= staging, out_partial <= ~&word_mask, word_mask <= 0,
//           out_valid <= 1, go to HOLD. Latency: commit write at cycle t gives out_valid at t+1.
//   HOLD  - out_data and out_valid stay stable until out_valid && out_ready.
//           On that handshake: out_valid <= 0, clr_idx <= 0, go to SWEEP.
//   SWEEP - clr_en = 1, clr_id = BASE_ID+clr_idx, one index per cycle for SAMPLES+1 cycles
//           (VALID id last). Then: if pending, clear pending and perform the IDLE commit
//           action (enter HOLD); otherwise go to IDLE.
//  A commit request arriving in HOLD or SWEEP sets pending; further requests saturate (no queue
//   depth >1). Staging keeps accumulating in these states, so the later commit uses the newest data.
//  out_ready while out_valid = 0 has no effect. clr_en = 0 outside SWEEP.
//  busy = (state != IDLE).
// STRUCTURE
//  mem_layout_pkg: add typedef enum logic[1:0] {BR_IDLE, BR_HOLD, BR_SWEEP} bigreg_state_t.
//   Existing `*_BASE_ID/`*_SAMPLES macros parameterise instances; no new constants.
//  One sub-module: fresh_clear_sweeper (start, BASE_ID, count -> clr_en/clr_id/done),
//   a counter FSM reusable by RTL_BIGREG blocks.
// TESTING
//  1 Seed instance (BASE 1, SAMPLES 16): write ids 1..16 with k*0x111, then id 17
//    -> out_valid at +1 cycle, out_data entry k = k*0x111, out_partial = 0.
//  2 Hold out_ready low for 20 cycles -> out_data stable; then out_ready = 1 for 1 cycle
//    -> clr_en for ids 1..17 on 17 consecutive cycles, then busy = 0.
//  3 Chmux instance (BASE 32, SAMPLES 2): write id 32 only, then id 34
//    -> out_partial = 1, entry1 = previous value.
//  4 During HOLD: write id 33 = 0xBEEF, then id 34; release ready
//    -> after 3 sweep cycles, out_valid rises again with entry1 = 0xBEEF.
//  5 Writes to ids 0, 31, 35 and wr_data[31:16] = 0xFFFF
//    -> no staging change, upper bits never appear in out_data.
//  6 Assert rst in the 2nd SWEEP cycle -> all outputs 0 the same cycle; next commit works normally.

Source files
------------

// File: rtl/ps_bigreg_assembler_pkg.sv
// ps_bigreg_assembler_pkg: shared widths and FSM encoding for the PS_BIGREG assemblers.
package ps_bigreg_assembler_pkg;
   localparam int WD_BUS_WIDTH = 32;
   typedef logic [1:0] bigreg_state_t;
   localparam bigreg_state_t BR_IDLE = 2'd0;
   localparam bigreg_state_t BR_HOLD = 2'd1;
   localparam bigreg_state_t BR_SWEEP = 2'd2;
endpackage

// File: rtl/ps_bigreg_assembler_if.sv
// ps_bigreg_assembler_if: mem-map write side, committed output handshake and fresh-bit clear bus.
interface ps_bigreg_assembler_if #(
   parameter int SAMPLES = 16,
   parameter int ID_W = 8,
   parameter int WORD_W = 16
);
   import ps_bigreg_assembler_pkg::*;
   logic wr_en;
   logic [ID_W-1:0] wr_id;
   logic [WD_BUS_WIDTH-1:0] wr_data;
   logic [SAMPLES*WORD_W-1:0] out_data;
   logic out_valid;
   logic out_ready;
   logic out_partial;
   logic clr_en;
   logic [ID_W-1:0] clr_id;
   logic busy;
   modport master (
      output wr_en, wr_id, wr_data, out_ready,
      input out_data, out_valid, out_partial, clr_en, clr_id, busy
   );
   modport slave (
      input wr_en, wr_id, wr_data, out_ready,
      output out_data, out_valid, out_partial, clr_en, clr_id, busy
   );
endinterface

// File: rtl/ps_bigreg_assembler_fresh_clear_sweeper.sv
// fresh_clear_sweeper: after start, strobes clr_id = BASE_ID..BASE_ID+COUNT-1 one per cycle.
module fresh_clear_sweeper #(
   parameter int ID_W = 8,
   parameter logic [ID_W-1:0] BASE_ID = '0,
   parameter int COUNT = 17
) (
   input logic clk,
   input logic rst,
   input logic start,
   output logic clr_en,
   output logic [ID_W-1:0] clr_id,
   output logic done
);
   localparam int CW = $clog2(COUNT + 1);
   logic [CW-1:0] idx;
   logic active;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         active <= 1'b0;
         idx <= '0;
      end else if (start) begin
         active <= 1'b1;
         idx <= '0;
      end else if (done) begin
         active <= 1'b0;
         idx <= '0;
      end else if (active)
         idx <= idx + CW'(1);
   assign done = active && idx == CW'(COUNT - 1);
   assign clr_en = active;
   assign clr_id = BASE_ID + ID_W'(idx);
endmodule

// File: rtl/ps_bigreg_assembler.sv
// ps_bigreg_assembler: stages SAMPLES mem-map words, commits them on the VALID id write,
// then sweeps the fresh bits of BASE_ID..BASE_ID+SAMPLES clear.
module ps_bigreg_assembler
   import ps_bigreg_assembler_pkg::*;
#(
   parameter int BASE_ID = 1,
   parameter int SAMPLES = 16,
   parameter int ID_W = 8,
   parameter int WORD_W = 16
) (
   input logic clk,
   input logic rst,
   ps_bigreg_assembler_if.slave bus
);
   localparam int IW = SAMPLES > 1 ? $clog2(SAMPLES) : 1;
   localparam logic [ID_W-1:0] BASE = ID_W'(BASE_ID);
   localparam logic [ID_W-1:0] VALID = ID_W'(BASE_ID + SAMPLES);
   bigreg_state_t state;
   logic [SAMPLES*WORD_W-1:0] staging, out_data;
   logic [SAMPLES-1:0] word_mask, mask_next;
   logic [ID_W-1:0] off;
   logic [IW-1:0] slot;
   logic stage_wr, req, pending, out_valid, out_partial, start, done, commit, unused_wr_data;
   assign off = bus.wr_id - BASE;
   assign slot = off[IW-1:0];
   assign stage_wr = bus.wr_en && off < ID_W'(SAMPLES);
   assign req = bus.wr_en && bus.wr_id == VALID;
   assign start = state == BR_HOLD && out_valid && bus.out_ready;
   // a request queued during HOLD/SWEEP, or one landing on the last sweep cycle, recommits at once
   assign commit = (req && state == BR_IDLE) || (done && (pending || req));
   assign unused_wr_data = ^bus.wr_data;
   always_comb mask_next = (commit ? '0 : word_mask) | (stage_wr ? SAMPLES'(1) << slot : '0);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= BR_IDLE;
         staging <= '0;
         out_data <= '0;
         word_mask <= '0;
         pending <= 1'b0;
         out_valid <= 1'b0;
         out_partial <= 1'b0;
      end else begin
         word_mask <= mask_next;
         if (stage_wr) staging[slot*WORD_W +: WORD_W] <= bus.wr_data[WORD_W-1:0];
         pending <= !commit && (pending || (req && state != BR_IDLE));
         if (commit) begin
            out_data <= staging;
            out_partial <= ~&word_mask;
            out_valid <= 1'b1;
            state <= BR_HOLD;
         end else if (start) begin
            out_valid <= 1'b0;
            state <= BR_SWEEP;
         end else if (done)
            state <= BR_IDLE;
      end
   fresh_clear_sweeper #(.ID_W(ID_W), .BASE_ID(BASE), .COUNT(SAMPLES + 1)) u_sweep (
      .clk(clk),
      .rst(rst),
      .start(start),
      .clr_en(bus.clr_en),
      .clr_id(bus.clr_id),
      .done(done)
   );
   assign bus.out_data = out_data;
   assign bus.out_valid = out_valid;
   assign bus.out_partial = out_partial;
   assign bus.busy = state != BR_IDLE;
endmodule

// File: tb/tb_ps_bigreg_assembler.sv
// tb_ps_bigreg_assembler: seed (BASE 1 x16) and chmux (BASE 32 x2) instances on one shared write bus.
module tb_ps_bigreg_assembler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_en = 1'b0;
   logic [7:0] wr_id = '0;
   logic [31:0] wr_data = '0;
   logic s_ready = 1'b0;
   logic c_ready = 1'b0;
   int total = 0;
   int bad = 0;
   logic [255:0] s_exp;
   always #5 clk = ~clk;
   ps_bigreg_assembler_if #(.SAMPLES(16), .ID_W(8), .WORD_W(16)) s_if ();
   ps_bigreg_assembler_if #(.SAMPLES(2), .ID_W(8), .WORD_W(16)) c_if ();
   assign s_if.wr_en = wr_en;
   assign s_if.wr_id = wr_id;
   assign s_if.wr_data = wr_data;
   assign s_if.out_ready = s_ready;
   assign c_if.wr_en = wr_en;
   assign c_if.wr_id = wr_id;
   assign c_if.wr_data = wr_data;
   assign c_if.out_ready = c_ready;
   ps_bigreg_assembler #(.BASE_ID(1), .SAMPLES(16), .ID_W(8), .WORD_W(16)) u_seed (
      .clk(clk), .rst(rst), .bus(s_if.slave));
   ps_bigreg_assembler #(.BASE_ID(32), .SAMPLES(2), .ID_W(8), .WORD_W(16)) u_chmux (
      .clk(clk), .rst(rst), .bus(c_if.slave));

   task automatic wr(input logic [7:0] id, input logic [31:0] d);
      wr_en = 1'b1;
      wr_id = id;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (s_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", s_if.out_valid); end
      total++; if (s_if.out_data !== 256'd0) begin bad++; $display("FAIL reset_data: got %h want 0", s_if.out_data); end
      total++; if ({s_if.clr_en, s_if.busy, s_if.out_partial} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {s_if.clr_en, s_if.busy, s_if.out_partial}); end
      total++; if (s_if.clr_id !== 8'd1) begin bad++; $display("FAIL reset_clr_id_seed: got %0d want 1", s_if.clr_id); end
      total++; if (c_if.clr_id !== 8'd32) begin bad++; $display("FAIL reset_clr_id_chmux: got %0d want 32", c_if.clr_id); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_seed_commit();
      for (int k = 1; k <= 16; k++) begin
         wr(8'(k), 32'(k * 'h111));
         s_exp[(k-1)*16 +: 16] = 16'(k * 'h111);
      end
      total++; if (s_if.out_valid !== 1'b0) begin bad++; $display("FAIL seed_precommit_valid: got %b want 0", s_if.out_valid); end
      wr(8'd17, 32'h0);
      total++; if (s_if.out_valid !== 1'b1) begin bad++; $display("FAIL seed_commit_latency: got %b want 1", s_if.out_valid); end
      total++; if (s_if.out_data !== s_exp) begin bad++; $display("FAIL seed_data: got %h want %h", s_if.out_data, s_exp); end
      total++; if (s_if.out_partial !== 1'b0) begin bad++; $display("FAIL seed_partial: got %b want 0", s_if.out_partial); end
      total++; if (s_if.busy !== 1'b1) begin bad++; $display("FAIL seed_busy: got %b want 1", s_if.busy); end
   endtask

   task automatic test_hold_sweep();
      int unstable = 0;
      repeat (20) begin
         @(negedge clk);
         if (s_if.out_valid !== 1'b1 || s_if.out_data !== s_exp || s_if.clr_en !== 1'b0) unstable++;
      end
      total++; if (unstable !== 0) begin bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      total++; if (s_if.out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b want 0", s_if.out_valid); end
      for (int i = 0; i < 17; i++) begin
         total++;
         if (s_if.clr_en !== 1'b1 || s_if.clr_id !== 8'(1 + i)) begin
            bad++;
            $display("FAIL sweep_step%0d: got en=%b id=%0d want en=1 id=%0d", i, s_if.clr_en, s_if.clr_id, 1 + i);
         end
         @(negedge clk);
      end
      total++; if ({s_if.clr_en, s_if.busy} !== 2'b00) begin bad++; $display("FAIL sweep_end: got en,busy=%b want 00", {s_if.clr_en, s_if.busy}); end
   endtask

   task automatic test_chmux_partial();
      wr(8'd32, 32'h1111);
      wr(8'd33, 32'h2222);
      wr(8'd34, 32'h0);
      total++; if (c_if.out_data !== 32'h2222_1111 || c_if.out_partial !== 1'b0) begin bad++; $display("FAIL chmux_full: got %h p=%b want 22221111 p=0", c_if.out_data, c_if.out_partial); end
      c_ready = 1'b1;
      @(negedge clk);
      c_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (c_if.busy !== 1'b0) begin bad++; $display("FAIL chmux_drain: got busy=%b want 0", c_if.busy); end
      wr(8'd32, 32'h3333);
      wr(8'd34, 32'h0);
      total++; if (c_if.out_data !== 32'h2222_3333) begin bad++; $display("FAIL chmux_partial_data: got %h want 22223333", c_if.out_data); end
      total++; if (c_if.out_partial !== 1'b1) begin bad++; $display("FAIL chmux_partial_flag: got %b want 1", c_if.out_partial); end
   endtask

   task automatic test_hold_pending();
      wr(8'd33, 32'hBEEF);
      wr(8'd34, 32'h0);
      total++; if (c_if.out_data !== 32'h2222_3333 || c_if.out_valid !== 1'b1) begin bad++; $display("FAIL pending_hold_stable: got %h v=%b want 22223333 v=1", c_if.out_data, c_if.out_valid); end
      c_ready = 1'b1;
      @(negedge clk);
      c_ready = 1'b0;
      total++; if (c_if.out_valid !== 1'b0 || c_if.clr_id !== 8'd32) begin bad++; $display("FAIL pending_sweep1: got v=%b id=%0d want v=0 id=32", c_if.out_valid, c_if.clr_id); end
      repeat (2) @(negedge clk);
      total++; if (c_if.clr_en !== 1'b1 || c_if.clr_id !== 8'd34 || c_if.out_valid !== 1'b0) begin bad++; $display("FAIL pending_sweep3: got en=%b id=%0d v=%b want en=1 id=34 v=0", c_if.clr_en, c_if.clr_id, c_if.out_valid); end
      @(negedge clk);
      total++; if (c_if.out_valid !== 1'b1 || c_if.clr_en !== 1'b0) begin bad++; $display("FAIL pending_recommit: got v=%b en=%b want v=1 en=0", c_if.out_valid, c_if.clr_en); end
      total++; if (c_if.out_data !== 32'hBEEF_3333 || c_if.out_partial !== 1'b1) begin bad++; $display("FAIL pending_data: got %h p=%b want beef3333 p=1", c_if.out_data, c_if.out_partial); end
      c_ready = 1'b1;
      @(negedge clk);
      c_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (c_if.busy !== 1'b0 || c_if.out_valid !== 1'b0) begin bad++; $display("FAIL pending_drain: got busy=%b v=%b want 0 0", c_if.busy, c_if.out_valid); end
   endtask

   task automatic test_out_of_range();
      wr(8'd31, 32'hFFFF_5555);
      wr(8'd35, 32'hFFFF_6666);
      wr(8'd0, 32'hFFFF_7777);
      wr(8'd18, 32'hFFFF_8888);
      wr(8'd32, 32'hFFFF_1234);
      wr(8'd34, 32'hFFFF_FFFF);
      total++; if (c_if.out_data !== 32'hBEEF_1234 || c_if.out_partial !== 1'b1) begin bad++; $display("FAIL range_chmux: got %h p=%b want beef1234 p=1", c_if.out_data, c_if.out_partial); end
      wr(8'd17, 32'hFFFF_FFFF);
      total++; if (s_if.out_data !== s_exp) begin bad++; $display("FAIL range_seed_data: got %h want %h", s_if.out_data, s_exp); end
      total++; if (s_if.out_partial !== 1'b1 || s_if.out_valid !== 1'b1) begin bad++; $display("FAIL range_seed_flags: got p=%b v=%b want 1 1", s_if.out_partial, s_if.out_valid); end
   endtask

   task automatic test_reset_mid_sweep();
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      @(negedge clk);
      total++; if (s_if.clr_id !== 8'd2 || s_if.clr_en !== 1'b1) begin bad++; $display("FAIL mid_sweep_pos: got en=%b id=%0d want en=1 id=2", s_if.clr_en, s_if.clr_id); end
      rst = 1'b1;
      #1;
      total++; if ({s_if.clr_en, s_if.busy, s_if.out_valid, s_if.out_partial} !== 4'b0000) begin bad++; $display("FAIL async_reset_flags: got %b want 0000", {s_if.clr_en, s_if.busy, s_if.out_valid, s_if.out_partial}); end
      total++; if (s_if.out_data !== 256'd0 || s_if.clr_id !== 8'd1) begin bad++; $display("FAIL async_reset_state: got data=%h id=%0d want 0 1", s_if.out_data, s_if.clr_id); end
      total++; if (c_if.out_valid !== 1'b0 || c_if.busy !== 1'b0) begin bad++; $display("FAIL async_reset_chmux: got v=%b busy=%b want 0 0", c_if.out_valid, c_if.busy); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 16; k++) begin
         wr(8'(k), 32'(k * 'h0101));
         s_exp[(k-1)*16 +: 16] = 16'(k * 'h0101);
      end
      wr(8'd17, 32'h0);
      total++; if (s_if.out_valid !== 1'b1 || s_if.out_partial !== 1'b0) begin bad++; $display("FAIL post_reset_flags: got v=%b p=%b want 1 0", s_if.out_valid, s_if.out_partial); end
      total++; if (s_if.out_data !== s_exp) begin bad++; $display("FAIL post_reset_data: got %h want %h", s_if.out_data, s_exp); end
   endtask

   initial begin
      test_reset();
      test_seed_commit();
      test_hold_sweep();
      test_chmux_partial();
      test_hold_pending();
      test_out_of_range();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
